plru_replacement_ctrl: RTL and testbench
========================================

// Module: plru_replacement_ctrl
// PURPOSE
// - Owns the per-set 4-way tree-PLRU state table for a set-associative cache.
// - Accepts one access per cycle from the cache controller (set, hit/miss, hit way).
// - Returns the way to use: the hit way on a hit, the PLRU victim on a miss.
// - Marks the returned way MRU. Clears the table after reset and on flush.
// PARAMETERS
// - NUM_SETS   default 16                meaning: number of cache sets (power of 2, >= 2)
// - SET_IDX_W  default $clog2(NUM_SETS)  meaning: width of the set index
// PORTS
// - clk        in   1          system clock
// - rst        in   1          synchronous, active-high reset
// - flush      in   1          single-cycle pulse; re-clears all PLRU state
// - req_valid  in   1          access request present
// - req_ready  out  1          block can accept a request this cycle
// - req_set    in   SET_IDX_W  set index of the access
// - req_hit    in   1          1 = tag hit, 0 = miss (victim wanted)
// - req_way    in   2          hit way; ignored when req_hit = 0
// - rsp_valid  out  1          response valid
// - rsp_set    out  SET_IDX_W  set index of the response
// - rsp_way    out  2          way chosen: hit way or victim
// - init_busy  out  1          table clear in progress
// BEHAVIOUR
// - One clock (clk); reset rst is synchronous and active-high.
// - State encoding per set, 3 bits:
//   - [2] root: 0 = victim in ways 0/1, 1 = victim in ways 2/3
//   - [1] left leaf (ways 0/1); [0] right leaf (ways 2/3)
//   - Victim = root ? {1'b1, s[0]} : {1'b0, s[1]}
//   - Touch way w: s[2] = ~w[1]. If w[1] = 0, s[1] = ~w[0]; else s[0] = ~w[0].
//     The untouched leaf is unchanged.
// - Table storage is a flop array of NUM_SETS x 3 bits. The cleared value is 3'b000.
// - FSM states:
//   - INIT: a counter sweeps sets 0..NUM_SETS-1, one write of 3'b000 per cycle.
//     After writing the last set, go to RUN.
//   - RUN: normal operation.
//   - rst forces INIT with the counter at 0. flush in any state forces INIT with the counter at 0 on the next cycle.
// - Outputs under rst: req_ready = 0, rsp_valid = 0, init_busy = 1 (INIT state).
//   rsp_set and rsp_way reset to 0.
// - req_ready = (state == RUN) && !flush. This is combinational.
// - A request is accepted when req_valid && req_ready.
// - Accepting a request in INIT is impossible.
// - A clear after reset takes exactly NUM_SETS cycles. req_ready first rises in cycle NUM_SETS after rst deasserts.
// - Pipeline timing, for a request accepted in cycle N:
//   - At the cycle-N edge, the request is registered into stage S1.
//   - In cycle N+1, rsp_valid = 1. rsp_set is the registered set.
//   - In cycle N+1, rsp_way = the hit way, or the victim computed from table[set].
//   - At the end of cycle N+1, table[set] is written with touch(rsp_way). On a miss, the victim becomes MRU.
//   - The latency is exactly 1 cycle, at full throughput. There is no rsp backpressure.
// - Back-to-back accesses to the same set:
//   - The write at the end of cycle N+1 is visible to the request registered at that same edge.
//   - The consecutive victims must reflect every prior touch, with no stale reads.
// - If rsp_valid = 0, there is no table write from S1.
// - Flush with S1 valid:
//   - The S1 response is still driven in that cycle.
//   - The S1 table write is suppressed, because INIT overwrites the table.
// - Reset with S1 valid: the in-flight response is dropped, and rsp_valid = 0 on the next cycle.
// - req_way is ignored when req_hit = 0. Out-of-range req_set is impossible, because NUM_SETS is a power of 2.
// TESTING
// - Reset: hold rst for 2 cycles, then release.
//   - Expect init_busy = 1 and req_ready = 0 for exactly NUM_SETS = 16 cycles, then req_ready = 1.
// - Misses on set 3, every cycle, 5 times:
//   - rsp_way sequence is 0, 2, 1, 3, 0, each 1 cycle after acceptance.
// - Hit, then misses:
//   - Hit way 0 on set 5, then miss on set 5: expect rsp_way = 2.
//   - Then miss on set 6: expect rsp_way = 0, showing set independence.
// - Hit way 3 on set 1, then miss on set 1 in the next cycle: expect rsp_way = 0. This is the back-to-back same-set update.
// - Flush:
//   - After 3 misses on set 2, pulse flush while S1 is valid. Expect that response to be delivered.
//   - Expect req_ready = 0 for 16 cycles.
//   - Then a miss on set 2 returns rsp_way = 0.
// - Reset mid-stream: assert rst in the cycle after an accept. Expect rsp_valid = 0 on the next cycle and INIT to restart.

Source files
------------

// File: rtl/plru_replacement_ctrl.sv
// Per-set 4-way tree-PLRU replacement controller: one access per cycle, 1-cycle response,
// table cleared by a set-sweeping INIT phase after reset and on flush.
module plru_replacement_ctrl #(
    parameter int NUM_SETS  = 16,
    parameter int SET_IDX_W = $clog2(NUM_SETS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [SET_IDX_W-1:0] req_set,
    input  logic                 req_hit,
    input  logic [1:0]           req_way,
    output logic                 rsp_valid,
    output logic [SET_IDX_W-1:0] rsp_set,
    output logic [1:0]           rsp_way,
    output logic                 init_busy
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state;
    logic [SET_IDX_W-1:0] init_cnt;
    logic [2:0]           plru [NUM_SETS];

    logic                 s1_valid;
    logic [SET_IDX_W-1:0] s1_set;
    logic                 s1_hit;
    logic [1:0]           s1_way;

    logic [2:0] cur_state;
    logic [1:0] victim;
    logic [2:0] touched;
    logic       accept;

    function automatic logic [2:0] touch(input logic [2:0] s, input logic [1:0] w);
        logic [2:0] n;
        n    = s;
        n[2] = ~w[1];
        if (!w[1]) n[1] = ~w[0];
        else       n[0] = ~w[0];
        return n;
    endfunction

    assign req_ready = (state == RUN) && !flush;
    assign accept    = req_valid && req_ready;
    assign init_busy = (state == INIT);

    // The previous access's write lands on the same edge this request is registered,
    // so reading the table in the S1 cycle already sees every earlier touch.
    assign cur_state = plru[s1_set];
    assign victim    = cur_state[2] ? {1'b1, cur_state[0]} : {1'b0, cur_state[1]};
    assign rsp_valid = s1_valid;
    assign rsp_set   = s1_set;
    assign rsp_way   = !s1_valid ? 2'b00 : (s1_hit ? s1_way : victim);
    assign touched   = touch(cur_state, rsp_way);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
            s1_valid <= 1'b0;
            s1_set   <= '0;
            s1_hit   <= 1'b0;
            s1_way   <= 2'b00;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_set <= req_set;
                s1_hit <= req_hit;
                s1_way <= req_way;
            end
            if (flush) begin
                state    <= INIT;
                init_cnt <= '0;
            end else if (state == INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (init_cnt == SET_IDX_W'(NUM_SETS - 1)) state <= RUN;
            end
        end
    end

    // A flush or reset pending on the S1 write drops it; INIT rewrites the table anyway.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT)
                plru[init_cnt] <= 3'b000;
            else if (s1_valid && !flush)
                plru[s1_set] <= touched;
        end
    end

endmodule

// File: tb/tb_plru_replacement_ctrl.sv
// Directed self-checking bench for plru_replacement_ctrl: reset/flush clear timing,
// PLRU victim sequences, set independence and back-to-back same-set updates.
module tb_plru_replacement_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_set;
    logic       req_hit;
    logic [1:0] req_way;
    logic       rsp_valid;
    logic [3:0] rsp_set;
    logic [1:0] rsp_way;
    logic       init_busy;

    int checks   = 0;
    int failures = 0;
    int low_cycles;
    int busy_errs;
    logic [1:0] exp_seq [5];

    plru_replacement_ctrl #(.NUM_SETS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_set   (req_set),
        .req_hit   (req_hit),
        .req_way   (req_way),
        .rsp_valid (rsp_valid),
        .rsp_set   (rsp_set),
        .rsp_way   (rsp_way),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    // Drive one cycle's inputs just after the edge, then settle before sampling.
    task automatic applyStimulus(input logic r, input logic v, input logic [3:0] s,
                                 input logic h, input logic [1:0] w, input logic fl);
        @(posedge clk);
        #1;
        rst       = r;
        req_valid = v;
        req_set   = s;
        req_hit   = h;
        req_way   = w;
        flush     = fl;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic countInit(input string tag);
        low_cycles = 0;
        busy_errs  = 0;
        while (!req_ready && low_cycles < 100) begin
            if (init_busy !== 1'b1) busy_errs++;
            low_cycles++;
            applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
        end
        checkOutput({tag, "_ready_low_cycles"}, 8'(low_cycles), 8'd16);
        checkOutput({tag, "_busy_during_init"}, 8'(busy_errs), 8'd0);
        checkOutput({tag, "_busy_after_init"}, {7'd0, init_busy}, 8'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0;
        req_set = 4'd0; req_hit = 1'b0; req_way = 2'd0;

        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
        checkOutput("rst_req_ready", {7'd0, req_ready}, 8'd0);
        checkOutput("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
        checkOutput("rst_init_busy", {7'd0, init_busy}, 8'd1);
        checkOutput("rst_rsp_way", {6'd0, rsp_way}, 8'd0);
        checkOutput("rst_rsp_set", {4'd0, rsp_set}, 8'd0);

        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
        countInit("reset");

        // Five back-to-back misses on set 3 walk all four ways and wrap.
        exp_seq[0] = 2'd0; exp_seq[1] = 2'd2; exp_seq[2] = 2'd1;
        exp_seq[3] = 2'd3; exp_seq[4] = 2'd0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1, 4'd3, 1'b0, 2'd1, 1'b0);
            if (k > 0) begin
                checkOutput($sformatf("miss3_valid_%0d", k - 1), {7'd0, rsp_valid}, 8'd1);
                checkOutput($sformatf("miss3_way_%0d", k - 1), {6'd0, rsp_way}, {6'd0, exp_seq[k-1]});
            end
        end
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
        checkOutput("miss3_set_4", {4'd0, rsp_set}, 8'd3);
        checkOutput("miss3_way_4", {6'd0, rsp_way}, {6'd0, exp_seq[4]});
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
        checkOutput("idle_rsp_valid", {7'd0, rsp_valid}, 8'd0);

        applyStimulus(1'b0, 1'b1, 4'd5, 1'b1, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'd5, 1'b0, 2'd3, 1'b0);
        checkOutput("hit5_way", {6'd0, rsp_way}, 8'd0);
        applyStimulus(1'b0, 1'b1, 4'd6, 1'b0, 2'd2, 1'b0);
        checkOutput("miss5_set", {4'd0, rsp_set}, 8'd5);
        checkOutput("miss5_way", {6'd0, rsp_way}, 8'd2);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
        checkOutput("miss6_set", {4'd0, rsp_set}, 8'd6);
        checkOutput("miss6_way", {6'd0, rsp_way}, 8'd0);

        applyStimulus(1'b0, 1'b1, 4'd1, 1'b1, 2'd3, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'd1, 1'b0, 2'd3, 1'b0);
        checkOutput("hit1_way", {6'd0, rsp_way}, 8'd3);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
        checkOutput("miss1_way", {6'd0, rsp_way}, 8'd0);

        // Flush while the third miss on set 2 is still in S1.
        applyStimulus(1'b0, 1'b1, 4'd2, 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'd2, 1'b0, 2'd0, 1'b0);
        checkOutput("miss2_way_0", {6'd0, rsp_way}, 8'd0);
        applyStimulus(1'b0, 1'b1, 4'd2, 1'b0, 2'd0, 1'b0);
        checkOutput("miss2_way_1", {6'd0, rsp_way}, 8'd2);
        applyStimulus(1'b0, 1'b1, 4'd2, 1'b0, 2'd0, 1'b1);
        checkOutput("flush_rsp_valid", {7'd0, rsp_valid}, 8'd1);
        checkOutput("flush_rsp_way", {6'd0, rsp_way}, 8'd1);
        checkOutput("flush_req_ready", {7'd0, req_ready}, 8'd0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
        checkOutput("post_flush_rsp_valid", {7'd0, rsp_valid}, 8'd0);
        countInit("flush");
        applyStimulus(1'b0, 1'b1, 4'd2, 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
        checkOutput("post_flush_miss2_valid", {7'd0, rsp_valid}, 8'd1);
        checkOutput("post_flush_miss2_way", {6'd0, rsp_way}, 8'd0);

        // Set 5 holds 011 here (victim way 1) unless the reset clear wipes it.
        applyStimulus(1'b0, 1'b1, 4'd4, 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
        checkOutput("midrst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
        checkOutput("midrst_init_busy", {7'd0, init_busy}, 8'd1);
        countInit("midrst");
        applyStimulus(1'b0, 1'b1, 4'd5, 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
        checkOutput("post_rst_miss5_valid", {7'd0, rsp_valid}, 8'd1);
        checkOutput("post_rst_miss5_way", {6'd0, rsp_way}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
